// File: rtl/periph_bus_pkg.sv
// Shared types and constants for the cluster peripheral request/response bus.
// Single-cycle decode helpers only; no state lives here.
package periph_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic OPC_OK  = 1'b0;
  localparam logic OPC_ERR = 1'b1;
  localparam logic RD      = 1'b1;
  localparam logic WR      = 1'b0;

  // Register index width; a single-register bank still decodes one address bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/periph_reg_bank.sv
// Register storage: byte-enable bus writes merged over full-word hardware updates.
// Updates land on the clock edge; no backpressure, every strobe is accepted.
module periph_reg_bank
  import periph_bus_pkg::*;
#(
  parameter int                     NUM_REGS  = 16,
  parameter int                     IW        = idx_width(NUM_REGS),
  parameter logic [NUM_REGS-1:0]    RO_MASK   = '0,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bus_we,
  input  logic [IW-1:0]            bus_idx,
  input  logic [31:0]              bus_wdata,
  input  logic [3:0]               bus_be,
  input  logic [NUM_REGS-1:0]      hw_we,
  input  logic [NUM_REGS*32-1:0]   hw_wdata,
  output logic [NUM_REGS*32-1:0]   reg_q
);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    logic [31:0] q;
    logic [3:0]  bus_hit;

    assign bus_hit = {4{bus_we && (bus_idx == IW'(i)) && !RO_MASK[i]}} & bus_be;
    assign reg_q[32*i +: 32] = q;

    // Bus bytes take priority; untouched bytes fall through to the hw word.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= RESET_VAL[32*i +: 32];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (bus_hit[b]) begin
            q[8*b +: 8] <= bus_wdata[8*b +: 8];
          end else if (hw_we[i]) begin
            q[8*b +: 8] <= hw_wdata[32*i + 8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/periph_regfile_slave.sv
// Peripheral-bus responder into a register bank; response WAIT_CYCLES+1 cycles after grant.
// Grant withheld while waiting; responses are single-cycle pulses with no response backpressure.
module periph_regfile_slave
  import periph_bus_pkg::*;
#(
  parameter int                     ID_WIDTH    = 9,
  parameter int                     NUM_REGS    = 16,
  parameter int                     WAIT_CYCLES = 0,
  parameter logic [NUM_REGS-1:0]    RO_MASK     = '0,
  parameter logic [NUM_REGS*32-1:0] RESET_VAL   = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_i,
  input  logic [31:0]              add_i,
  input  logic                     wen_i,
  input  logic [31:0]              wdata_i,
  input  logic [3:0]               be_i,
  input  logic [ID_WIDTH-1:0]      id_i,
  output logic                     gnt_o,
  output logic                     r_valid_o,
  output logic                     r_opc_o,
  output logic [ID_WIDTH-1:0]      r_id_o,
  output logic [31:0]              r_rdata_o,
  output logic [NUM_REGS*32-1:0]   reg_q_o,
  input  logic [NUM_REGS-1:0]      hw_we_i,
  input  logic [NUM_REGS*32-1:0]   hw_wdata_i
);

  localparam int IW = idx_width(NUM_REGS);

  state_e              state;
  logic [3:0]          cnt;
  logic [ID_WIDTH-1:0] lat_id;
  logic                lat_wen;
  logic                lat_err;
  logic [IW-1:0]       lat_idx;

  logic [IW-1:0]       idx;
  logic [IW-1:0]       rd_idx;
  logic [31:0]         rd_word;
  logic                in_range;
  logic                ro_hit;
  logic                err;
  logic                hs;
  logic                bus_we;
  logic                unused_add;

  // The crossbar has already matched the base, so upper address bits are dropped.
  assign idx        = add_i[2 +: IW];
  assign unused_add = ^add_i[31:2+IW];

  always_comb begin
    in_range = 1'b0;
    ro_hit   = 1'b0;
    rd_word  = '0;
    rd_idx   = (state == WAIT) ? lat_idx : idx;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IW'(i)) begin
        in_range = 1'b1;
        ro_hit   = RO_MASK[i];
      end
      if (rd_idx == IW'(i)) begin
        rd_word = reg_q_o[32*i +: 32];
      end
    end
  end

  assign err    = (|add_i[1:0]) | ~in_range | ((wen_i == WR) & ro_hit);
  assign gnt_o  = req_i & ((state == IDLE) | (state == RESP));
  assign hs     = gnt_o;
  assign bus_we = hs & (wen_i == WR) & ~err;

  periph_reg_bank #(
    .NUM_REGS  (NUM_REGS),
    .IW        (IW),
    .RO_MASK   (RO_MASK),
    .RESET_VAL (RESET_VAL)
  ) u_bank (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .bus_we    (bus_we),
    .bus_idx   (idx),
    .bus_wdata (wdata_i),
    .bus_be    (be_i),
    .hw_we     (hw_we_i),
    .hw_wdata  (hw_wdata_i),
    .reg_q     (reg_q_o)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_id    <= '0;
      lat_wen   <= RD;
      lat_err   <= OPC_OK;
      lat_idx   <= '0;
      r_valid_o <= 1'b0;
      r_opc_o   <= OPC_OK;
      r_id_o    <= '0;
      r_rdata_o <= '0;
    end else begin
      r_valid_o <= 1'b0;
      r_opc_o   <= OPC_OK;
      r_id_o    <= '0;
      r_rdata_o <= '0;
      case (state)
        IDLE, RESP: begin
          if (hs) begin
            lat_id  <= id_i;
            lat_wen <= wen_i;
            lat_idx <= idx;
            lat_err <= err;
            if (WAIT_CYCLES == 0) begin
              // Read data sampled on this edge, so a write one cycle earlier is visible.
              state     <= RESP;
              r_valid_o <= 1'b1;
              r_id_o    <= id_i;
              r_opc_o   <= err ? OPC_ERR : OPC_OK;
              r_rdata_o <= ((wen_i == RD) && !err) ? rd_word : 32'h0;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            r_valid_o <= 1'b1;
            r_id_o    <= lat_id;
            r_opc_o   <= lat_err ? OPC_ERR : OPC_OK;
            r_rdata_o <= ((lat_wen == RD) && !lat_err) ? rd_word : 32'h0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_regfile_slave.sv
// Bench: two responders (0 and 3 wait states) driven side by side, responses scored from a queue.
module tb_periph_regfile_slave;
  import periph_bus_pkg::*;

  localparam int NR  = 12;
  localparam int IDW = 9;
  localparam logic [NR-1:0] ROM = 12'h001;

  function automatic logic [NR*32-1:0] mk_rv();
    logic [NR*32-1:0] v;
    for (int i = 0; i < NR; i++) v[32*i +: 32] = (i == 1) ? 32'h11223344 : (32'hC0DE0000 | 32'(i));
    return v;
  endfunction
  localparam logic [NR*32-1:0] RV = mk_rv();

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n    [2];
  logic              req      [2];
  logic [31:0]       add      [2];
  logic              wen      [2];
  logic [31:0]       wdata    [2];
  logic [3:0]        be       [2];
  logic [IDW-1:0]    id       [2];
  logic              gnt      [2];
  logic              r_valid  [2];
  logic              r_opc    [2];
  logic [IDW-1:0]    r_id     [2];
  logic [31:0]       r_rdata  [2];
  logic [NR*32-1:0]  reg_q    [2];
  logic [NR-1:0]     hw_we    [2];
  logic [NR*32-1:0]  hw_wdata [2];

  periph_regfile_slave #(.ID_WIDTH(IDW), .NUM_REGS(NR), .WAIT_CYCLES(0), .RO_MASK(ROM), .RESET_VAL(RV)) dut0 (
    .clk_i(clk), .rst_ni(rst_n[0]), .req_i(req[0]), .add_i(add[0]), .wen_i(wen[0]),
    .wdata_i(wdata[0]), .be_i(be[0]), .id_i(id[0]), .gnt_o(gnt[0]), .r_valid_o(r_valid[0]),
    .r_opc_o(r_opc[0]), .r_id_o(r_id[0]), .r_rdata_o(r_rdata[0]), .reg_q_o(reg_q[0]),
    .hw_we_i(hw_we[0]), .hw_wdata_i(hw_wdata[0]));

  periph_regfile_slave #(.ID_WIDTH(IDW), .NUM_REGS(NR), .WAIT_CYCLES(3), .RO_MASK(ROM), .RESET_VAL(RV)) dut3 (
    .clk_i(clk), .rst_ni(rst_n[1]), .req_i(req[1]), .add_i(add[1]), .wen_i(wen[1]),
    .wdata_i(wdata[1]), .be_i(be[1]), .id_i(id[1]), .gnt_o(gnt[1]), .r_valid_o(r_valid[1]),
    .r_opc_o(r_opc[1]), .r_id_o(r_id[1]), .r_rdata_o(r_rdata[1]), .reg_q_o(reg_q[1]),
    .hw_we_i(hw_we[1]), .hw_wdata_i(hw_wdata[1]));

  typedef struct {
    int             unit;
    logic [IDW-1:0] id;
    logic           opc;
    logic [31:0]    rdata;
    int             cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] mdl[2][NR];

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: every r_valid must match the oldest pending entry for that unit.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (r_valid[u] === 1'b1) begin
        int   k;
        exp_t e;
        k = -1;
        for (int j = 0; j < sbq.size(); j++) begin
          if (sbq[j].unit == u) begin
            k = j;
            break;
          end
        end
        checks++;
        if (k < 0) begin
          errors++;
          $display("FAIL unexpected_rvalid unit%0d: got r_valid=1 r_id=%h, required no response", u, r_id[u]);
        end else begin
          e = sbq[k];
          sbq.delete(k);
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL rvalid_cycle unit%0d id=%h: got cycle %0d, required %0d", u, e.id, cyc, e.cyc);
          end
          checks++;
          if (r_id[u] !== e.id) begin
            errors++;
            $display("FAIL r_id unit%0d: got %h, required %h", u, r_id[u], e.id);
          end
          checks++;
          if (r_opc[u] !== e.opc) begin
            errors++;
            $display("FAIL r_opc unit%0d id=%h: got %b, required %b", u, e.id, r_opc[u], e.opc);
          end
          checks++;
          if (r_rdata[u] !== e.rdata) begin
            errors++;
            $display("FAIL r_rdata unit%0d id=%h: got %h, required %h", u, e.id, r_rdata[u], e.rdata);
          end
        end
      end
    end
  end

  task automatic issue(input int u, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] b, input logic [IDW-1:0] i, input logic exp_gnt);
    logic [3:0] ix;
    logic       e;
    exp_t       x;
    req[u] = 1'b1; add[u] = a; wen[u] = w; wdata[u] = d; be[u] = b; id[u] = i;
    @(negedge clk);
    checks++;
    if (gnt[u] !== exp_gnt) begin
      errors++;
      $display("FAIL gnt unit%0d addr=%h: got %b, required %b", u, a, gnt[u], exp_gnt);
    end
    if (gnt[u] === 1'b1) begin
      ix = a[5:2];
      e  = (a[1:0] != 2'b00) || (ix >= NR) || (w == WR && ROM[ix]);
      x.unit  = u;
      x.id    = i;
      x.opc   = e;
      x.cyc   = cyc + 1 + ((u == 0) ? 0 : 3);
      x.rdata = (w == RD && !e) ? mdl[u][ix] : 32'h0;
      if (w == WR && !e) begin
        for (int bb = 0; bb < 4; bb++) if (b[bb]) mdl[u][ix][8*bb +: 8] = d[8*bb +: 8];
      end
      sbq.push_back(x);
    end
    @(posedge clk);
    #1;
    req[u] = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && sbq.size() > 0; k++) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sbq.size());
    end
  endtask

  task automatic check_regs(input int u, input string tag);
    for (int r = 0; r < NR; r++) begin
      checks++;
      if (reg_q[u][32*r +: 32] !== mdl[u][r]) begin
        errors++;
        $display("FAIL %s unit%0d reg%0d: got %h, required %h", tag, u, r, reg_q[u][32*r +: 32], mdl[u][r]);
      end
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      rst_n[u] = 1'b0; req[u] = 1'b0; add[u] = '0; wen[u] = RD; wdata[u] = '0;
      be[u] = '0; id[u] = '0; hw_we[u] = '0; hw_wdata[u] = '0;
      for (int r = 0; r < NR; r++) mdl[u][r] = RV[32*r +: 32];
    end
    #12;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if ({r_valid[u], r_opc[u], r_id[u], r_rdata[u]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs unit%0d: got valid=%b opc=%b id=%h rdata=%h, required all 0",
                 u, r_valid[u], r_opc[u], r_id[u], r_rdata[u]);
      end
      check_regs(u, "reset_regs");
    end
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_basic();
    issue(0, 32'h08, RD, 32'h0, 4'h0, 9'd5, 1'b1);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(0, 32'h04, WR, 32'hAABBCCDD, 4'b0101, 9'd1, 1'b1);
    issue(0, 32'h04, RD, 32'h0, 4'h0, 9'd2, 1'b1);
    drain();
    checks++;
    if (reg_q[0][32 +: 32] !== 32'h11BB33DD) begin
      errors++;
      $display("FAIL be_merge reg1: got %h, required %h", reg_q[0][32 +: 32], 32'h11BB33DD);
    end
  endtask

  task automatic test_wait_states();
    issue(1, 32'h08, RD, 32'h0, 4'h0, 9'd7, 1'b1);
    repeat (3) issue(1, 32'h04, RD, 32'h0, 4'h0, 9'd8, 1'b0);
    issue(1, 32'h04, RD, 32'h0, 4'h0, 9'd8, 1'b1);
    drain();
  endtask

  task automatic test_errors();
    issue(0, 32'h02, RD, 32'h0, 4'h0, 9'd10, 1'b1);
    issue(0, 32'h30, RD, 32'h0, 4'h0, 9'd11, 1'b1);
    issue(0, 32'h00, WR, 32'hFFFFFFFF, 4'hF, 9'd12, 1'b1);
    issue(1, 32'h00, WR, 32'h12345678, 4'hF, 9'd13, 1'b1);
    drain();
    checks++;
    if (reg_q[0][31:0] !== RV[31:0]) begin
      errors++;
      $display("FAIL ro_write reg0: got %h, required %h", reg_q[0][31:0], RV[31:0]);
    end
    check_regs(0, "err_regs");
    check_regs(1, "err_regs");
  endtask

  task automatic test_hw_merge();
    hw_wdata[0] = '0;
    hw_wdata[0][3*32 +: 32] = 32'hFFFFFFFF;
    hw_we[0] = 12'h008;
    issue(0, 32'h0C, WR, 32'h00000012, 4'b0001, 9'd20, 1'b1);
    hw_we[0] = '0;
    mdl[0][3] = 32'hFFFFFF12;
    checks++;
    if (reg_q[0][3*32 +: 32] !== 32'hFFFFFF12) begin
      errors++;
      $display("FAIL hw_merge reg3: got %h, required %h", reg_q[0][3*32 +: 32], 32'hFFFFFF12);
    end
    hw_wdata[0][5*32 +: 32] = 32'h5A5A0001;
    hw_we[0] = 12'h020;
    @(posedge clk);
    #1;
    hw_we[0] = '0;
    mdl[0][5] = 32'h5A5A0001;
    issue(0, 32'h0C, RD, 32'h0, 4'h0, 9'd21, 1'b1);
    issue(0, 32'h14, RD, 32'h0, 4'h0, 9'd22, 1'b1);
    drain();
  endtask

  task automatic test_reset_in_wait();
    issue(1, 32'h08, WR, 32'hDEADBEEF, 4'hF, 9'h1AB, 1'b1);
    @(negedge clk);
    checks++;
    if (reg_q[1][2*32 +: 32] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wait_write reg2: got %h, required %h", reg_q[1][2*32 +: 32], 32'hDEADBEEF);
    end
    rst_n[1] = 1'b0;
    for (int j = sbq.size() - 1; j >= 0; j--) if (sbq[j].unit == 1) sbq.delete(j);
    for (int r = 0; r < NR; r++) mdl[1][r] = RV[32*r +: 32];
    #1;
    check_regs(1, "midwait_reset_regs");
    @(posedge clk);
    #1;
    rst_n[1] = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    issue(1, 32'h08, RD, 32'h0, 4'h0, 9'd3, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic [3:0]  ix;
    logic [1:0]  lo;
    for (int n = 0; n < 40; n++) begin
      ix = 4'($urandom_range(0, 15));
      lo = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue(0, {26'h0, ix, lo}, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
            9'($urandom_range(0, 511)), 1'b1);
    end
    drain();
    check_regs(0, "random_regs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_basic();
    test_back_to_back();
    test_wait_states();
    test_errors();
    test_hw_merge();
    test_reset_in_wait();
    test_random();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL leftover_responses: got %0d pending, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
